scan_sequencer: RTL and testbench
=================================

Name: scan_sequencer

Overview:
- Channel-scan address generator directly upstream of the per-channel threshold/hit-counting stage.
- On a synchronous start pulse it waits one arm cycle, then steps the bus address through every channel, one per clock, with `running` high.
- Downstream stages use the arm cycle, where `ss` is seen with `running` low, to clear their hit counters.
- Reports end-of-scan and keeps a count of completed scans for readout.

Parameters:
- N_CHAN, 256, number of channels scanned per pass (1..2**ADDR_W).
- ADDR_W, 9, width of the channel address bus.
- SCNT_W, 16, width of the completed-scan counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- ss  in  1  synchronous start pulse
- abort  in  1  synchronous abort of the current scan
- running  out  1  high while a valid channel address is on `addr`
- addr  out  ADDR_W  channel address driven to the data bus
- last  out  1  high during the cycle `addr` == N_CHAN-1 while running
- done  out  1  one-cycle pulse after a scan completes normally
- busy  out  1  high in ARM or SCAN
- scan_cnt  out  SCNT_W  number of normally completed scans

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - running = 0, addr = 0, last = 0, done = 0, busy = 0, scan_cnt = 0.
- States and transitions:
  - IDLE: on ss = 1 go to ARM. ss is ignored in every other state; no restart.
  - ARM: exactly one cycle; running = 0, busy = 1. Always advances to SCAN. addr is held at 0 here.
  - SCAN: running = 1, busy = 1.
    - addr increments by 1 each clock, starting at 0.
    - When addr == N_CHAN-1, the next state is DONE.
  - DONE: one cycle.
    - done = 1, running = 0, busy = 0.
    - scan_cnt increments on entry into DONE.
    - Next state is IDLE.
- Latency:
  - ss sampled at edge E0: ARM during E0..E1; SCAN with addr = 0 from E1.
  - The last address is presented in cycle N_CHAN after ARM.
  - done is asserted N_CHAN+1 cycles after ARM begins.
  - Total from ss to done = N_CHAN+2 clocks.
- Outputs:
  - All outputs are registered; no combinational path from any input to any output.
  - last = running & (addr == N_CHAN-1).
- Abort:
  - Sampled in ARM or SCAN: next cycle state = IDLE, running = 0, addr = 0.
  - No done pulse; scan_cnt unchanged.
  - Abort in IDLE or DONE has no effect.
- Simultaneous events:
  - abort has priority over the SCAN→DONE transition on the last address.
  - ss together with abort in IDLE: start wins; abort is ignored because it is sampled in IDLE.
  - ss during DONE is ignored; a new scan needs ss in IDLE.
- Wrap-around:
  - scan_cnt wraps from 2**SCNT_W-1 to 0 silently.
  - addr never exceeds N_CHAN-1.
- N_CHAN = 1: SCAN lasts one cycle with addr = 0 and last = 1.
- Reset mid-scan: outputs return to reset values immediately and asynchronously; the scan is lost.

Optional Feature:
- Macro SCAN_REPEAT_EN.
- Defined:
  - Adds input `repeat_mode` (1 bit).
  - When repeat_mode = 1, DONE goes to ARM instead of IDLE, so scans continue back-to-back. done pulses and scan_cnt increments per pass.
  - Deasserting repeat_mode lets the current pass finish, then the block returns to IDLE.
  - abort still stops immediately.
- Undefined: port absent; behaviour exactly as above.

Decomposition:
- Shared package scan_pkg:
  - state enum (IDLE, ARM, SCAN, DONE), 2-bit encoding.
  - Default constants N_CHAN_DEF = 256, ADDR_W_DEF = 9, SCNT_W_DEF = 16.
  - The downstream hit-counter stage also uses these defaults, so its 9-bit hit count matches ADDR_W.
- One sub-module: scan_addr_ctr.
  - Loadable, clearable, enable-gated address counter with terminal-count flag.
  - Reused later by the readout address stage.

Test Plan:
- Basic scan: reset, then N_CHAN=4, ss pulse at cycle 10.
  - running = 0 at 11.
  - running = 1 with addr 0,1,2,3 at 12..15; last = 1 at 15.
  - done = 1 at 16; scan_cnt = 1.
- Abort mid-scan: N_CHAN=256, abort while addr = 100.
  - Next cycle running = 0, addr = 0, busy = 0.
  - No done pulse; scan_cnt unchanged.
- Abort on last address: abort when addr = 255.
  - No done pulse; scan_cnt unchanged (abort priority).
- ss ignored while busy: ss pulses during ARM, at addr = 50, and during DONE.
  - Exactly one scan of 256 addresses; scan_cnt += 1.
- Async reset at addr = 37, applied between clock edges.
  - All outputs go to 0 before the next edge; the next ss starts a fresh scan at addr 0.
- SCAN_REPEAT_EN, repeat_mode = 1, N_CHAN = 4.
  - Pattern ARM, 4×SCAN, DONE repeats every 6 cycles.
  - scan_cnt = 3 after 18 cycles.
  - Drop repeat_mode and the block idles after the current DONE.

Source files
------------

// File: rtl/scan_sequencer_pkg.sv
// Shared types and default sizing for the channel-scan sequencer and its downstream
// hit-counter stage (a 9-bit hit count lines up with ADDR_W_DEF).
package scan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      SCAN = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int N_CHAN_DEF = 256;
   localparam int ADDR_W_DEF = 9;
   localparam int SCNT_W_DEF = 16;

endpackage

// File: rtl/scan_sequencer_if.sv
// Control/address bus between the scan sequencer (master) and the per-channel stage (slave).
// With SCAN_REPEAT_EN defined the bus also carries repeat_mode.
interface scan_sequencer_if
   import scan_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int SCNT_W = SCNT_W_DEF
);
   logic              ss;
   logic              abort;
`ifdef SCAN_REPEAT_EN
   logic              repeat_mode;
`endif
   logic              running;
   logic [ADDR_W-1:0] addr;
   logic              last;
   logic              done;
   logic              busy;
   logic [SCNT_W-1:0] scan_cnt;

`ifdef SCAN_REPEAT_EN
   modport master (input ss, abort, repeat_mode,
                   output running, addr, last, done, busy, scan_cnt);
   modport slave  (output ss, abort, repeat_mode,
                   input running, addr, last, done, busy, scan_cnt);
`else
   modport master (input ss, abort,
                   output running, addr, last, done, busy, scan_cnt);
   modport slave  (output ss, abort,
                   input running, addr, last, done, busy, scan_cnt);
`endif
endinterface

// File: rtl/scan_addr_ctr.sv
// Loadable, clearable, enable-gated address counter with terminal-count flag.
// nxt_o exposes the value the counter takes on the coming edge.
module scan_addr_ctr #(
   parameter int           W  = 9,
   parameter logic [W-1:0] TC = '1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         ld_i,
   input  logic [W-1:0] ld_val_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic [W-1:0] nxt_o,
   output logic         tc_o
);
   logic [W-1:0] cnt_q, cnt_d;

   // Clear beats load beats increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (ld_i) cnt_d = ld_val_i;
      else if (en_i) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
   assign nxt_o = cnt_d;
   assign tc_o  = (cnt_q == TC);

endmodule

// File: rtl/scan_sequencer.sv
// Channel-scan address generator: ss -> one ARM cycle -> N_CHAN addresses -> one DONE cycle.
// Optional SCAN_REPEAT_EN: repeat_mode on the bus chains passes back-to-back.
module scan_sequencer
   import scan_pkg::*;
#(
   parameter int N_CHAN = N_CHAN_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int SCNT_W = SCNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   scan_sequencer_if.master bus
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CHAN - 1);

   state_e            state_q, state_d;
   logic              running_q, running_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              last_q, last_d;
   logic [SCNT_W-1:0] scan_cnt_q;
   logic [ADDR_W-1:0] addr_cur, addr_nxt;
   logic              at_last, repeat_req, ctr_clr, ctr_en;

`ifdef SCAN_REPEAT_EN
   assign repeat_req = bus.repeat_mode;
`else
   assign repeat_req = 1'b0;
`endif

   // abort is only honoured in ARM/SCAN and wins over the SCAN->DONE step.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.ss) state_d = ARM;
         ARM:     state_d = bus.abort ? IDLE : SCAN;
         SCAN: begin
            if (bus.abort)    state_d = IDLE;
            else if (at_last) state_d = DONE;
         end
         DONE:    state_d = repeat_req ? ARM : IDLE;
         default: state_d = IDLE;
      endcase
      running_d = (state_d == SCAN);
      busy_d    = (state_d == ARM) || (state_d == SCAN);
      done_d    = (state_d == DONE);
   end

   // Address is zero outside SCAN; the ARM->SCAN edge holds it at 0 so the first
   // scan cycle presents channel 0.
   assign ctr_clr = (state_d != SCAN);
   assign ctr_en  = (state_q == SCAN);
   assign last_d  = running_d && (addr_nxt == LAST_ADDR);

   scan_addr_ctr #(
      .W  (ADDR_W),
      .TC (LAST_ADDR)
   ) u_addr_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (ctr_clr),
      .ld_i     (1'b0),
      .ld_val_i ('0),
      .en_i     (ctr_en),
      .cnt_o    (addr_cur),
      .nxt_o    (addr_nxt),
      .tc_o     (at_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         running_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         last_q     <= 1'b0;
         scan_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         running_q <= running_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         last_q    <= last_d;
         if (done_d) scan_cnt_q <= scan_cnt_q + 1'b1;
      end
   end

   assign bus.running  = running_q;
   assign bus.addr     = addr_cur;
   assign bus.last     = last_q;
   assign bus.done     = done_q;
   assign bus.busy     = busy_q;
   assign bus.scan_cnt = scan_cnt_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: two instances (N_CHAN=4 and N_CHAN=256);
// expected addresses and scan counts are queued at start and popped as the DUT emits them.
`timescale 1ns/1ps
module tb_scan_sequencer;
   localparam int NA = 4;
   localparam int NB = 256;
   localparam int AW = 9;
   localparam int CW = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   scan_sequencer_if #(.ADDR_W(AW), .SCNT_W(CW)) ifa ();
   scan_sequencer_if #(.ADDR_W(AW), .SCNT_W(CW)) ifb ();

   scan_sequencer #(.N_CHAN(NA), .ADDR_W(AW), .SCNT_W(CW)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa)
   );
   scan_sequencer #(.N_CHAN(NB), .ADDR_W(AW), .SCNT_W(CW)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb)
   );

   int n_chk = 0;
   int n_err = 0;
   int exp_addr_a[$];
   int exp_addr_b[$];
   int exp_cnt_a[$];
   int exp_cnt_b[$];
   int cnt_a = 0;
   int cnt_b = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Scoreboard side: every running cycle must match the next queued address,
   // every done pulse must match the next queued scan count.
   always @(negedge clk) begin : mon_a
      int e;
      if (rst_n) begin
         chk("a_run_unqueued", ifa.running && exp_addr_a.size() == 0, 0);
         if (ifa.running && exp_addr_a.size() != 0) begin
            e = exp_addr_a.pop_front();
            chk("a_addr", ifa.addr, e);
            chk("a_last", ifa.last, e == NA - 1);
         end else begin
            chk("a_last_idle", ifa.last, 0);
         end
         chk("a_done_unqueued", ifa.done && exp_cnt_a.size() == 0, 0);
         if (ifa.done && exp_cnt_a.size() != 0) begin
            e = exp_cnt_a.pop_front();
            chk("a_scan_cnt", ifa.scan_cnt, e);
            chk("a_done_busy", ifa.busy, 0);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      int e;
      if (rst_n) begin
         chk("b_run_unqueued", ifb.running && exp_addr_b.size() == 0, 0);
         if (ifb.running && exp_addr_b.size() != 0) begin
            e = exp_addr_b.pop_front();
            chk("b_addr", ifb.addr, e);
            chk("b_last", ifb.last, e == NB - 1);
         end else begin
            chk("b_last_idle", ifb.last, 0);
         end
         chk("b_done_unqueued", ifb.done && exp_cnt_b.size() == 0, 0);
         if (ifb.done && exp_cnt_b.size() != 0) begin
            e = exp_cnt_b.pop_front();
            chk("b_scan_cnt", ifb.scan_cnt, e);
            chk("b_done_busy", ifb.busy, 0);
         end
      end
   end

   // Called at a negedge: raises ss for one cycle and queues one full pass.
   task automatic start_b();
      ifb.ss = 1'b1;
      for (int i = 0; i < NB; i++) exp_addr_b.push_back(i);
      cnt_b++;
      exp_cnt_b.push_back(cnt_b);
      @(negedge clk);
      ifb.ss = 1'b0;
   endtask

   task automatic pulse_b_ss();
      ifb.ss = 1'b1;
      @(negedge clk);
      ifb.ss = 1'b0;
   endtask

   task automatic wait_b_addr(input int v);
      int k = 0;
      while (!(ifb.running && ifb.addr == v) && k < 600) begin
         @(negedge clk);
         k++;
      end
      chk("b_reach_addr", ifb.running && ifb.addr == v, 1);
   endtask

   task automatic wait_done(input bit b);
      int k = 0;
      while (!(b ? ifb.done : ifa.done) && k < 600) begin
         @(negedge clk);
         k++;
      end
      chk(b ? "b_done_seen" : "a_done_seen", b ? ifb.done : ifa.done, 1);
   endtask

   // Abort sampled on the next edge; the scan in flight is dropped from the scoreboard.
   task automatic abort_b();
      ifb.abort = 1'b1;
      @(posedge clk);
      #1;
      ifb.abort = 1'b0;
      exp_addr_b.delete();
      exp_cnt_b.delete();
      cnt_b--;
      @(negedge clk);
      chk("b_abort_running", ifb.running, 0);
      chk("b_abort_addr", ifb.addr, 0);
      chk("b_abort_busy", ifb.busy, 0);
      chk("b_abort_cnt", ifb.scan_cnt, cnt_b);
      repeat (6) @(negedge clk);
      chk("b_abort_idle_cnt", ifb.scan_cnt, cnt_b);
   endtask

   initial begin
      int t1, t2, t3;
      ifa.ss = 1'b0; ifa.abort = 1'b0;
      ifb.ss = 1'b0; ifb.abort = 1'b0;
`ifdef SCAN_REPEAT_EN
      ifa.repeat_mode = 1'b0;
      ifb.repeat_mode = 1'b0;
`endif
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_running", ifb.running, 0);
      chk("rst_addr", ifb.addr, 0);
      chk("rst_last", ifb.last, 0);
      chk("rst_done", ifb.done, 0);
      chk("rst_busy", ifb.busy, 0);
      chk("rst_scan_cnt", ifb.scan_cnt, 0);
      chk("rst_a_busy", ifa.busy, 0);
      rst_n = 1'b1;
      repeat (7) @(negedge clk);

      // Basic N_CHAN=4 scan with cycle-exact latency.
      ifa.ss = 1'b1;
      for (int i = 0; i < NA; i++) exp_addr_a.push_back(i);
      cnt_a++;
      exp_cnt_a.push_back(cnt_a);
      @(negedge clk);
      ifa.ss = 1'b0;
      chk("a_arm_running", ifa.running, 0);
      chk("a_arm_busy", ifa.busy, 1);
      chk("a_arm_addr", ifa.addr, 0);
      repeat (NA) @(negedge clk);
      chk("a_last_cycle", ifa.last, 1);
      @(negedge clk);
      chk("a_done_latency", ifa.done, 1);
      chk("a_cnt_one", ifa.scan_cnt, 1);
      @(negedge clk);
      chk("a_done_pulse", ifa.done, 0);
      chk("a_idle_busy", ifa.busy, 0);
      chk("a_q_drained", exp_addr_a.size(), 0);

      // Abort in the middle of an N_CHAN=256 scan.
      start_b();
      wait_b_addr(100);
      abort_b();

      // Abort on the last address beats completion.
      start_b();
      wait_b_addr(NB - 1);
      chk("b_last_at_end", ifb.last, 1);
      abort_b();

      // ss during ARM, mid-scan and DONE is ignored.
      start_b();
      chk("b_arm_busy", ifb.busy, 1);
      pulse_b_ss();
      wait_b_addr(50);
      pulse_b_ss();
      @(negedge clk);
      wait_done(1'b1);
      pulse_b_ss();
      repeat (10) @(negedge clk);
      chk("b_one_scan_q", exp_addr_b.size(), 0);
      chk("b_one_scan_cnt", ifb.scan_cnt, cnt_b);
      chk("b_one_scan_busy", ifb.busy, 0);

      // Asynchronous reset between edges at addr 37.
      start_b();
      wait_b_addr(37);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_running", ifb.running, 0);
      chk("arst_addr", ifb.addr, 0);
      chk("arst_busy", ifb.busy, 0);
      chk("arst_scan_cnt", ifb.scan_cnt, 0);
      chk("arst_a_cnt", ifa.scan_cnt, 0);
      exp_addr_b.delete();
      exp_cnt_b.delete();
      cnt_b = 0;
      cnt_a = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_b();
      @(negedge clk);
      wait_done(1'b1);
      @(negedge clk);
      chk("arst_fresh_q", exp_addr_b.size(), 0);
      chk("arst_fresh_cnt", ifb.scan_cnt, 1);

`ifdef SCAN_REPEAT_EN
      // Back-to-back passes on the N_CHAN=4 instance, then drop repeat_mode.
      ifa.repeat_mode = 1'b1;
      ifa.ss = 1'b1;
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < NA; i++) exp_addr_a.push_back(i);
         cnt_a++;
         exp_cnt_a.push_back(cnt_a);
      end
      @(negedge clk);
      ifa.ss = 1'b0;
      wait_done(1'b0);
      t1 = cyc;
      @(negedge clk);
      chk("rep_arm_busy", ifa.busy, 1);
      wait_done(1'b0);
      t2 = cyc;
      @(negedge clk);
      ifa.repeat_mode = 1'b0;
      wait_done(1'b0);
      t3 = cyc;
      chk("rep_period_1", t2 - t1, NA + 2);
      chk("rep_period_2", t3 - t2, NA + 2);
      chk("rep_cnt_three", ifa.scan_cnt, 3);
      repeat (4) @(negedge clk);
      chk("rep_idle_busy", ifa.busy, 0);
      chk("rep_idle_running", ifa.running, 0);
      chk("rep_q_drained", exp_addr_a.size(), 0);
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
